// File: rtl/multi_tick_gen_if.sv
// Control/status bundle for multi_tick_gen: per-channel enables and modes, the shared
// period write port, and the tick/busy/error outputs.
interface multi_tick_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 26
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] mode;
  logic              sync;
  logic              period_wr;
  logic [SEL_W-1:0]  period_sel;
  logic [CNT_W-1:0]  period_din;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] busy;
  logic              wr_err;

  modport master (
    output en, mode, sync, period_wr, period_sel, period_din,
    input  tick, busy, wr_err
  );

  modport slave (
    input  en, mode, sync, period_wr, period_sel, period_din,
    output tick, busy, wr_err
  );
endinterface

// File: rtl/multi_tick_gen.sv
// NUM_CH independent programmable tick generators sharing one clock, a global re-phase
// strobe and a single period write port with shadowed, glitch-free period updates.
module multi_tick_gen #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 26,
  parameter int DEF_PERIOD = 50_000_000
) (
  input logic             clk,
  input logic             rst_n,
  multi_tick_gen_if.slave bus
);

  localparam int              SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);

  logic [CNT_W-1:0]  cnt     [NUM_CH];
  logic [CNT_W-1:0]  p_act   [NUM_CH];
  logic [CNT_W-1:0]  p_shd   [NUM_CH];
  logic [CNT_W-1:0]  shd_nxt [NUM_CH];
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] tick_p0;
  logic              wr_err_p0;
  logic [NUM_CH-1:0] wr_hit;
  logic              wr_ok;

  function automatic logic at_wrap(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] p);
    return c == (p - CNT_W'(1));
  endfunction

  // Decode the write port; a zero period or an unmapped select hits no channel.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.period_sel == SEL_W'(i))
        wr_hit[i] = bus.period_wr && (bus.period_din != '0);
    end
    wr_ok = |wr_hit;
    for (int i = 0; i < NUM_CH; i++)
      shd_nxt[i] = wr_hit[i] ? bus.period_din : p_shd[i];
  end

  // Stage p0: counters, period registers and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]   <= '0;
        p_act[i] <= DEF_P;
        p_shd[i] <= DEF_P;
      end
      done      <= '0;
      tick_p0   <= '0;
      wr_err_p0 <= 1'b0;
    end else begin
      wr_err_p0 <= bus.period_wr & ~wr_ok;
      for (int i = 0; i < NUM_CH; i++) begin
        p_shd[i] <= shd_nxt[i];
        if (bus.sync) begin
          cnt[i]     <= '0;
          done[i]    <= 1'b0;
          tick_p0[i] <= 1'b0;
        end else if (!bus.en[i]) begin
          cnt[i]     <= '0;
          done[i]    <= 1'b0;
          tick_p0[i] <= 1'b0;
          p_act[i]   <= shd_nxt[i];
        end else if (done[i]) begin
          cnt[i]     <= '0;
          tick_p0[i] <= 1'b0;
        end else if (at_wrap(cnt[i], p_act[i])) begin
          // shd_nxt lets a write landing on the wrap edge take effect right away
          cnt[i]     <= '0;
          tick_p0[i] <= 1'b1;
          p_act[i]   <= shd_nxt[i];
          if (bus.mode[i]) done[i] <= 1'b1;
        end else begin
          cnt[i]     <= cnt[i] + CNT_W'(1);
          tick_p0[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.tick   = tick_p0;
  assign bus.busy   = bus.en & ~done;
  assign bus.wr_err = wr_err_p0;

endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed scenarios plus a randomized run for multi_tick_gen, checked every cycle
// against a countdown-based reference model and against hand-derived tick positions.
module tb_multi_tick_gen;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int DEFP   = 5;

  logic clk;
  logic rst_n;

  multi_tick_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  multi_tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_PERIOD(DEFP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int t;

  // Reference model: each channel counts down the edges remaining until its next tick.
  int          m_rem  [NUM_CH];
  int          m_act  [NUM_CH];
  int          m_shd  [NUM_CH];
  bit          m_done [NUM_CH];
  logic [NUM_CH-1:0] exp_tick;
  logic              exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_rem[i] = DEFP; m_act[i] = DEFP; m_shd[i] = DEFP; m_done[i] = 1'b0;
    end
    exp_tick = '0;
    exp_err  = 1'b0;
  endtask

  task automatic model_edge();
    int nshd;
    if (!rst_n) begin
      model_reset();
      return;
    end
    exp_err = bus.period_wr && (bus.period_din == 0 || int'(bus.period_sel) >= NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      nshd = m_shd[i];
      if (bus.period_wr && bus.period_din != 0 && int'(bus.period_sel) == i)
        nshd = int'(bus.period_din);
      exp_tick[i] = 1'b0;
      if (bus.sync) begin
        m_rem[i] = m_act[i]; m_done[i] = 1'b0;
      end else if (!bus.en[i]) begin
        m_act[i] = nshd; m_rem[i] = nshd; m_done[i] = 1'b0;
      end else if (m_done[i]) begin
        // finished one-shot waits for re-arm
      end else if (m_rem[i] == 1) begin
        exp_tick[i] = 1'b1;
        m_act[i] = nshd; m_rem[i] = nshd; m_done[i] = bus.mode[i];
      end else begin
        m_rem[i]--;
      end
      m_shd[i] = nshd;
    end
  endtask

  function automatic logic [NUM_CH-1:0] done_vec();
    logic [NUM_CH-1:0] d;
    for (int i = 0; i < NUM_CH; i++) d[i] = m_done[i];
    return d;
  endfunction

  // One clock: update the model at the edge, then compare 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    t++;
    chk("tick",   32'(bus.tick),   32'(exp_tick));
    chk("busy",   32'(bus.busy),   32'(bus.en & ~done_vec()));
    chk("wr_err", 32'(bus.wr_err), 32'(exp_err));
  endtask

  task automatic wr(input int sel, input int din);
    bus.period_wr  = 1'b1;
    bus.period_sel = 2'(sel);
    bus.period_din = 8'(din);
    cyc();
    bus.period_wr  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    t = 0;
    rst_n          = 1'b0;
    bus.en         = '0;
    bus.mode       = '0;
    bus.sync       = 1'b0;
    bus.period_wr  = 1'b0;
    bus.period_sel = '0;
    bus.period_din = '0;
    model_reset();

    // Reset state
    cyc(); cyc();
    chk("rst_tick", 32'(bus.tick), 32'h0);
    chk("rst_err",  32'(bus.wr_err), 32'h0);
    rst_n = 1'b1;

    // T1: default period 5 on ch0
    bus.en[0] = 1'b1; t = 0;
    for (int k = 0; k < 17; k++) begin
      cyc();
      chk("t1_tick0", 32'(bus.tick[0]), 32'(t % 5 == 0));
    end

    // T2: ch1 one-shot, period 3
    wr(1, 3);
    bus.mode[1] = 1'b1; bus.en[1] = 1'b1; t = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("t2_tick1", 32'(bus.tick[1]), 32'(t == 3));
      chk("t2_busy1", 32'(bus.busy[1]), 32'(t < 3));
    end
    bus.en[1] = 1'b0; cyc();
    bus.en[1] = 1'b1; t = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t2_rearm", 32'(bus.tick[1]), 32'(t == 3));
    end
    bus.en[1] = 1'b0;

    // T3: shadowed period write and write on the wrap edge
    bus.en[0] = 1'b0;
    wr(0, 8);
    bus.en[0] = 1'b1; t = 0;
    cyc(); cyc();
    wr(0, 4);
    while (t < 15) begin
      cyc();
      chk("t3_tick_a", 32'(bus.tick[0]), 32'(t == 8 || t == 12));
    end
    wr(0, 6);
    chk("t3_wrap_wr", 32'(bus.tick[0]), 32'h1);
    while (t < 29) begin
      cyc();
      chk("t3_tick_b", 32'(bus.tick[0]), 32'(t == 22 || t == 28));
    end

    // T4: rejected writes
    wr(0, 0);
    chk("t4_err_zero", 32'(bus.wr_err), 32'h1);
    wr(3, 5);
    chk("t4_err_sel", 32'(bus.wr_err), 32'h1);
    cyc();
    chk("t4_err_low", 32'(bus.wr_err), 32'h0);
    for (int k = 0; k < 8; k++) cyc();

    // T5: periods 4 and 6, out of phase, then sync
    bus.en = '0;
    wr(0, 4);
    wr(2, 6);
    bus.en[0] = 1'b1; cyc(); cyc();
    bus.en[2] = 1'b1; cyc(); cyc(); cyc();
    bus.sync = 1'b1; t = 0;
    cyc();
    bus.sync = 1'b0;
    chk("t5_sync_tick", 32'(bus.tick), 32'h0);
    t = 0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("t5_tick0", 32'(bus.tick[0]), 32'(t == 4));
      chk("t5_tick2", 32'(bus.tick[2]), 32'(t == 6));
    end

    // T6: async reset in the middle of a tick cycle
    begin
      int n = 0;
      while (exp_tick[0] !== 1'b1 && n < 10) begin cyc(); n++; end
      chk("t6_reach_tick", 32'(exp_tick[0]), 32'h1);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async_tick", 32'(bus.tick), 32'h0);
    cyc(); cyc();
    rst_n = 1'b1;
    bus.en = 3'b001; t = 0;
    for (int k = 0; k < 11; k++) begin
      cyc();
      chk("t6_def_tick", 32'(bus.tick[0]), 32'(t == 5 || t == 10));
    end

    // Randomized run against the model
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(9) == 0) bus.en[i]   = ~bus.en[i];
        if ($urandom_range(15) == 0) bus.mode[i] = ~bus.mode[i];
      end
      bus.sync       = ($urandom_range(29) == 0);
      bus.period_wr  = ($urandom_range(5) == 0);
      bus.period_sel = 2'($urandom_range(3));
      bus.period_din = 8'($urandom_range(9));
      cyc();
    end
    bus.sync = 1'b0; bus.period_wr = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
